// File: rtl/stage_sequencer_pkg.sv
// Shared types, constants and stage-search helpers for the pipe-stage-2 sequencer.
package stage_seq_pkg;
    localparam int PARA       = 16;
    localparam int NUM_STAGES = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [2:0]                      stage_t;
    typedef logic [PARA-1:0]                 beat_t;
    typedef logic [NUM_STAGES-1:0][PARA-1:0] lens_t;

    localparam stage_t STAGE_FINISHED = 3'd7;

    // Only stage 1 runs the reconfig tile in its alternate mode.
    function automatic logic mode_of(input stage_t stage);
        return (stage == 3'd1) ? 1'b0 : 1'b1;
    endfunction

    // Lowest stage index >= lo holding a nonzero beat count, else STAGE_FINISHED.
    function automatic stage_t first_from(input int lo, input lens_t lens);
        stage_t found;
        found = STAGE_FINISHED;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            found = ((i >= lo) && (lens[i] != {PARA{1'b0}})) ? stage_t'(i) : found;
        end
        return found;
    endfunction

    function automatic stage_t next_stage(input stage_t stage, input lens_t lens);
        return first_from(int'(stage) + 1, lens);
    endfunction

    function automatic logic lens_exceed(input lens_t lens, input beat_t max_beats);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bad = bad | (lens[i] > max_beats);
        end
        return bad;
    endfunction
endpackage

// File: rtl/stage_sequencer_if.sv
// Operand-read and result-tag handshake between the sequencer and its neighbours.
interface stage_sequencer_if;
    import stage_seq_pkg::*;

    logic   in_valid_i;
    logic   in_ready_o;
    beat_t  rd_addr_o;
    logic   out_valid_o;
    logic   out_ready_i;
    stage_t out_stage_o;
    beat_t  out_beat_o;

    modport master (
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output rd_addr_o,
        output out_valid_o,
        output out_stage_o,
        output out_beat_o
    );

    modport slave (
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  rd_addr_o,
        input  out_valid_o,
        input  out_stage_o,
        input  out_beat_o
    );
endinterface

// File: rtl/stage_sequencer_out_reg.sv
// One-entry valid/ready register holding a {stage, beat} result tag.
module stage_out_reg
    import stage_seq_pkg::*;
(
    input  logic   CLK_i,
    input  logic   RST_i,
    input  logic   i_load,
    input  logic   i_ready,
    input  stage_t i_stage,
    input  beat_t  i_beat,
    output logic   o_valid,
    output stage_t o_stage,
    output beat_t  o_beat
);
    logic   r_valid;
    stage_t r_stage;
    beat_t  r_beat;

    // A load wins over a clear so accept-and-refill happens without a bubble.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_valid <= 1'b0;
            r_stage <= 3'd0;
            r_beat  <= {PARA{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_stage <= i_stage;
            r_beat  <= i_beat;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_stage = r_stage;
    assign o_beat  = r_beat;
endmodule

// File: rtl/stage_sequencer.sv
// Start/done FSM that walks per-stage beat counts for the stage-2 datapath.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int N             = 4096,
    parameter int PARALLEL_SIZE = 2
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  start_i,
    input  lens_t                 stage_len_i,
    stage_sequencer_if.master     bus,
    output logic                  stall_o,
    output stage_t                stage_o,
    output logic                  mode_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);
    localparam beat_t MAX_BEATS = beat_t'(N / PARALLEL_SIZE);
    localparam beat_t ADDR_STEP = beat_t'(PARALLEL_SIZE);

    state_e r_state;
    stage_t r_stage;
    logic   r_mode;
    beat_t  r_beat;
    beat_t  r_addr;
    lens_t  r_lens;
    logic   r_cfg_err;

    logic   w_out_valid;
    logic   w_fire;
    logic   w_last;
    logic   w_cfg_bad;
    beat_t  w_cur_len;
    stage_t w_first;
    stage_t w_next;

    // Fire when an operand is present and the output slot is free or being drained.
    always_comb begin
        w_fire    = 1'b0;
        w_cur_len = {PARA{1'b0}};
        if (r_stage != STAGE_FINISHED) begin
            w_cur_len = r_lens[r_stage];
        end else begin
            w_cur_len = {PARA{1'b0}};
        end
        if (r_state == RUN) begin
            w_fire = bus.in_valid_i && !(w_out_valid && !bus.out_ready_i);
        end else begin
            w_fire = 1'b0;
        end
    end

    assign w_last    = (r_beat == (w_cur_len - beat_t'(1)));
    assign w_cfg_bad = lens_exceed(stage_len_i, MAX_BEATS);
    assign w_first   = first_from(0, stage_len_i);
    assign w_next    = next_stage(r_stage, r_lens);

    // Sequencer FSM: stage walk, beat/address counters and configuration check.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_state   <= IDLE;
            r_stage   <= STAGE_FINISHED;
            r_mode    <= 1'b1;
            r_beat    <= {PARA{1'b0}};
            r_addr    <= {PARA{1'b0}};
            r_lens    <= '{default: {PARA{1'b0}}};
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_lens <= stage_len_i;
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b0;
                            r_beat    <= {PARA{1'b0}};
                            r_addr    <= {PARA{1'b0}};
                            r_stage   <= w_first;
                            r_mode    <= mode_of(w_first);
                            r_state   <= (w_first == STAGE_FINISHED) ? DONE : RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (w_fire && w_last) begin
                        r_beat  <= {PARA{1'b0}};
                        r_addr  <= {PARA{1'b0}};
                        r_stage <= w_next;
                        r_mode  <= mode_of(w_next);
                        r_state <= (w_next == STAGE_FINISHED) ? DRAIN : RUN;
                    end else if (w_fire) begin
                        r_beat <= r_beat + beat_t'(1);
                        r_addr <= r_addr + ADDR_STEP;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (!w_out_valid || bus.out_ready_i) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_stage <= STAGE_FINISHED;
                    r_mode  <= 1'b1;
                end
            endcase
        end
    end

    stage_out_reg u_out_reg (
        .CLK_i   (CLK_i),
        .RST_i   (RST_i),
        .i_load  (w_fire),
        .i_ready (bus.out_ready_i),
        .i_stage (r_stage),
        .i_beat  (r_beat),
        .o_valid (w_out_valid),
        .o_stage (bus.out_stage_o),
        .o_beat  (bus.out_beat_o)
    );

    assign bus.out_valid_o = w_out_valid;
    assign bus.in_ready_o  = w_fire;
    assign bus.rd_addr_o   = r_addr;
    assign stall_o         = !w_fire;
    assign stage_o         = r_stage;
    assign mode_o          = r_mode;
    assign busy_o          = (r_state != IDLE);
    assign done_o          = (r_state == DONE);
    assign cfg_err_o       = r_cfg_err;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a queue-based expectation model.
module tb_stage_sequencer;
    import stage_seq_pkg::*;

    logic   CLK_i = 1'b0;
    logic   RST_i = 1'b1;
    logic   start_i = 1'b0;
    lens_t  stage_len_i = '{default: 16'd0};
    logic   stall_o, mode_o, busy_o, done_o, cfg_err_o;
    stage_t stage_o;

    stage_sequencer_if bus ();

    stage_sequencer #(.N(4096), .PARALLEL_SIZE(2)) dut (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .start_i     (start_i),
        .stage_len_i (stage_len_i),
        .bus         (bus),
        .stall_o     (stall_o),
        .stage_o     (stage_o),
        .mode_o      (mode_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 CLK_i = ~CLK_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK_i) cyc <= cyc + 1;

    // Model: every run must issue then retire (stage, beat) for each nonzero stage in order.
    int  issue_q[$];
    int  acc_q[$];
    bit  cmp_en = 1'b0;

    int  fire_stage[$], fire_addr[$], fire_mode[$], fire_cyc[$];
    int  acc_tag[$], acc_cyc[$];
    int  done_count = 0, done_cyc = -1, start_cyc = -1, last_fire_cyc = -1;
    int  ov_count = 0, stall_low_count = 0;
    bit  prev_hold = 1'b0;
    int  prev_tag = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_load(input lens_t l);
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int b = 0; b < int'(l[s]); b++) begin
                issue_q.push_back(s * 65536 + b);
                acc_q.push_back(s * 65536 + b);
            end
        end
    endtask

    // Observer and per-cycle comparison against the model.
    always @(negedge CLK_i) begin
        int e;
        int tag;
        tag = int'(bus.out_stage_o) * 65536 + int'(bus.out_beat_o);
        if (RST_i || !cmp_en) begin
            prev_hold = 1'b0;
        end else begin
            if (start_i && !busy_o) start_cyc = cyc;
            if (done_o) begin done_count++; done_cyc = cyc; end
            if (bus.out_valid_o) ov_count++;
            if (!stall_o) stall_low_count++;
            check("mode_rule", int'(mode_o), (stage_o == 3'd1) ? 0 : 1);
            check("stall_rule", int'(stall_o), bus.in_ready_o ? 0 : 1);
            if (bus.out_valid_o && !bus.out_ready_i) check("blocked_no_fire", int'(bus.in_ready_o), 0);
            if (prev_hold) begin
                check("hold_valid", int'(bus.out_valid_o), 1);
                check("hold_tag", tag, prev_tag);
            end
            if (bus.in_ready_o) begin
                fire_stage.push_back(int'(stage_o));
                fire_addr.push_back(int'(bus.rd_addr_o));
                fire_mode.push_back(int'(mode_o));
                fire_cyc.push_back(cyc);
                last_fire_cyc = cyc;
                if (issue_q.size() == 0) begin
                    check("spurious_issue", 1, 0);
                end else begin
                    e = issue_q.pop_front();
                    check("issue_stage", int'(stage_o), e / 65536);
                    check("issue_addr", int'(bus.rd_addr_o), (e % 65536) * 2);
                end
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                acc_tag.push_back(tag);
                acc_cyc.push_back(cyc);
                if (acc_q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = acc_q.pop_front();
                    check("result_tag", tag, e);
                end
            end
            prev_hold = bus.out_valid_o && !bus.out_ready_i;
            prev_tag  = tag;
        end
    end

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic do_start(input lens_t l, input bit expect_ok);
        if (expect_ok) model_load(l);
        start_i     = 1'b1;
        stage_len_i = l;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_pulses"}, done_count - d0, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_stage"}, int'(stage_o), 7);
        check({name, "_mode"}, int'(mode_o), 1);
        check({name, "_stall"}, int'(stall_o), 1);
        check({name, "_busy"}, int'(busy_o), 0);
        check({name, "_done"}, int'(done_o), 0);
        check({name, "_cfg_err"}, int'(cfg_err_o), 0);
        check({name, "_out_valid"}, int'(bus.out_valid_o), 0);
        check({name, "_in_ready"}, int'(bus.in_ready_o), 0);
        check({name, "_rd_addr"}, int'(bus.rd_addr_o), 0);
        check({name, "_out_stage"}, int'(bus.out_stage_o), 0);
        check({name, "_out_beat"}, int'(bus.out_beat_o), 0);
    endtask

    initial begin
        lens_t l;
        int    base, d0, ov0, sl0, n;
        int    t1_exp[6];
        t1_exp = '{0, 1, 2, 2 * 65536, 2 * 65536 + 1, 6 * 65536};

        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #12;
        check_reset_vals("por");
        tick();
        RST_i  = 1'b0;
        cmp_en = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        tick();

        // Three-stage mix with free-flowing handshakes.
        l = '{default: 16'd0}; l[0] = 16'd3; l[2] = 16'd2; l[6] = 16'd1;
        base = acc_tag.size();
        n = fire_mode.size();
        do_start(l, 1'b1);
        check("t1_busy_t1", int'(busy_o), 1);
        check("t1_stage_t1", int'(stage_o), 0);
        wait_done("t1", 50);
        check("t1_count", acc_tag.size() - base, 6);
        if (acc_tag.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_seq", acc_tag[base + i], t1_exp[i]);
                check("t1_consecutive", acc_cyc[base + i], acc_cyc[base] + i);
            end
            check("t1_first_latency", acc_cyc[base], start_cyc + 2);
        end
        for (int i = n; i < fire_mode.size(); i++) check("t1_mode", fire_mode[i], 1);
        check("t1_done_latency", done_cyc, last_fire_cyc + 2);
        check("t1_idle_after", int'(busy_o), 0);
        check("t1_model_empty", issue_q.size() + acc_q.size(), 0);

        // Stage 1 only: alternate tile mode and address stride.
        l = '{default: 16'd0}; l[1] = 16'd4;
        base = fire_addr.size();
        do_start(l, 1'b1);
        wait_done("t2", 50);
        check("t2_fires", fire_addr.size() - base, 4);
        if (fire_addr.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_addr", fire_addr[base + i], 2 * i);
                check("t2_stage", fire_stage[base + i], 1);
                check("t2_mode", fire_mode[base + i], 0);
            end
        end
        check("t2_stage_after", int'(stage_o), 7);

        // All stages skipped: immediate completion.
        l = '{default: 16'd0};
        ov0 = ov_count; sl0 = stall_low_count;
        do_start(l, 1'b1);
        wait_done("t3", 5);
        check("t3_done_latency", done_cyc, start_cyc + 1);
        check("t3_no_out_valid", ov_count - ov0, 0);
        check("t3_no_stall_low", stall_low_count - sl0, 0);

        // Over-long stage rejected, then the 2048-beat boundary accepted.
        l = '{default: 16'd0}; l[2] = 16'd2049;
        d0 = done_count;
        do_start(l, 1'b0);
        check("t4_cfg_err", int'(cfg_err_o), 1);
        check("t4_busy", int'(busy_o), 0);
        repeat (3) tick();
        check("t4_cfg_sticky", int'(cfg_err_o), 1);
        check("t4_still_idle", int'(busy_o), 0);
        check("t4_no_done", done_count - d0, 0);
        l = '{default: 16'd0}; l[2] = 16'd2048;
        base = acc_tag.size();
        do_start(l, 1'b1);
        check("t4_cfg_cleared", int'(cfg_err_o), 0);
        check("t4_running", int'(busy_o), 1);
        repeat (10) tick();
        start_i = 1'b1;
        stage_len_i[0] = 16'd5;
        tick();
        start_i = 1'b0;
        wait_done("t4", 2200);
        check("t4_count", acc_tag.size() - base, 2048);
        check("t4_model_empty", issue_q.size() + acc_q.size(), 0);

        // Consumer back-pressure mid-stage.
        l = '{default: 16'd0}; l[4] = 16'd6;
        base = acc_tag.size();
        do_start(l, 1'b1);
        tick();
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK_i); #1;
            check("t5_stall", int'(stall_o), 1);
            check("t5_in_ready", int'(bus.in_ready_o), 0);
            check("t5_held_valid", int'(bus.out_valid_o), 1);
            check("t5_held_tag", int'(bus.out_stage_o) * 65536 + int'(bus.out_beat_o), 4 * 65536);
            tick();
        end
        bus.out_ready_i = 1'b1;
        wait_done("t5", 50);
        check("t5_count", acc_tag.size() - base, 6);
        check("t5_model_empty", issue_q.size() + acc_q.size(), 0);

        // Asynchronous reset in stage 3 beat 1, then a clean restart.
        l = '{default: 16'd0}; l[0] = 16'd2; l[3] = 16'd3;
        do_start(l, 1'b1);
        n = 0;
        while (!(stage_o == 3'd3 && bus.rd_addr_o == 16'd2) && n < 20) begin
            @(negedge CLK_i); #1;
            n++;
        end
        check("t6_reached_s3b1", n < 20 ? 1 : 0, 1);
        RST_i  = 1'b1;
        cmp_en = 1'b0;
        #1;
        check_reset_vals("t6_abort");
        issue_q.delete();
        acc_q.delete();
        d0 = done_count;
        tick(); tick();
        RST_i  = 1'b0;
        cmp_en = 1'b1;
        repeat (4) tick();
        check("t6_no_done", done_count - d0, 0);
        check("t6_idle", int'(busy_o), 0);
        base = fire_stage.size();
        do_start(l, 1'b1);
        wait_done("t6", 50);
        check("t6_restart_fires", fire_stage.size() - base, 5);
        if (fire_stage.size() > base) begin
            check("t6_restart_stage", fire_stage[base], 0);
            check("t6_restart_addr", fire_addr[base], 0);
        end
        check("t6_model_empty", issue_q.size() + acc_q.size(), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
